// File: rtl/io_bank.sv
// io_bank: memory-mapped IO peripheral block with GPIO, a free-running
// timer with compare/interrupt, and an 8N1 UART transmitter.
module io_bank #(
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        uart_tx,
    output logic        irq
);

    // Register selector values (io_addr[4:2])
    localparam logic [2:0] R_GPIO_OUT = 3'd0;
    localparam logic [2:0] R_GPIO_IN  = 3'd1;
    localparam logic [2:0] R_COUNT    = 3'd2;
    localparam logic [2:0] R_CMP      = 3'd3;
    localparam logic [2:0] R_CTRL     = 3'd4;
    localparam logic [2:0] R_STATUS   = 3'd5;
    localparam logic [2:0] R_UART_TX  = 3'd6;
    localparam logic [2:0] R_UART_DIV = 3'd7;

    // UART transmitter states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [2:0]  sel;
    logic        wr;
    logic        unused_addr_bits;

    logic [7:0]  gpio_out_q, gpio_out_d;
    logic [7:0]  sync1_q, sync2_q;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        timer_en_q, timer_en_d;
    logic        irq_en_q, irq_en_d;
    logic        match_q, match_d;
    logic [15:0] div_q, div_d;

    logic [1:0]  state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] baud_q, baud_d;
    logic        tx_q, tx_d;
    logic [15:0] reload;
    logic        busy;

    assign sel              = io_addr[4:2];
    assign wr               = io_en & io_we;
    assign unused_addr_bits = ^{io_addr[7:5], io_addr[1:0]};

    assign busy     = (state_q != S_IDLE);
    assign gpio_out = gpio_out_q;
    assign uart_tx  = tx_q;
    assign irq      = match_q & irq_en_q;

    // A divider of zero behaves as one cycle per bit; the counter runs reload..0.
    assign reload = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);

    // Register-file next state: writes, timer increment and match flag
    always_comb begin
        gpio_out_d = gpio_out_q;
        cmp_d      = cmp_q;
        timer_en_d = timer_en_q;
        irq_en_d   = irq_en_q;
        div_d      = div_q;
        count_d    = timer_en_q ? (count_q + 32'd1) : count_q;
        match_d    = match_q;

        if (wr) begin
            case (sel)
                R_GPIO_OUT: gpio_out_d = io_data_write[7:0];
                R_COUNT:    count_d    = io_data_write;
                R_CMP:      cmp_d      = io_data_write;
                R_CTRL: begin
                    timer_en_d = io_data_write[0];
                    irq_en_d   = io_data_write[1];
                end
                R_UART_DIV: div_d      = io_data_write[15:0];
                default: ;
            endcase
        end

        // Clear first, then set, so a simultaneous set keeps the flag high.
        if (wr && (sel == R_STATUS) && io_data_write[0]) begin
            match_d = 1'b0;
        end
        if (timer_en_q && (count_q == cmp_q)) begin
            match_d = 1'b1;
        end
    end

    // UART next state: bit sequencing driven by the down-counting baud counter
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        baud_d  = baud_q;

        case (state_q)
            S_IDLE: begin
                if (wr && (sel == R_UART_TX)) begin
                    shift_d = io_data_write[7:0];
                    state_d = S_START;
                    baud_d  = reload;
                end
            end
            S_START: begin
                if (baud_q == 16'd0) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    baud_d  = reload;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = reload;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_STOP: begin
                if (baud_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is registered from the next state to keep uart_tx glitch-free.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    // Zero-latency read mux; idle bus reads as zero
    always_comb begin
        io_data_read = 32'h0;
        if (io_en) begin
            case (sel)
                R_GPIO_OUT: io_data_read = {24'h0, gpio_out_q};
                R_GPIO_IN:  io_data_read = {24'h0, sync2_q};
                R_COUNT:    io_data_read = count_q;
                R_CMP:      io_data_read = cmp_q;
                R_CTRL:     io_data_read = {30'h0, irq_en_q, timer_en_q};
                R_STATUS:   io_data_read = {30'h0, busy, match_q};
                R_UART_DIV: io_data_read = {16'h0, div_q};
                default:    io_data_read = 32'h0;
            endcase
        end
    end

    // Control and register state with synchronous reset dominating writes
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out_q <= 8'h0;
            sync1_q    <= 8'h0;
            sync2_q    <= 8'h0;
            count_q    <= 32'h0;
            cmp_q      <= 32'hFFFF_FFFF;
            timer_en_q <= 1'b0;
            irq_en_q   <= 1'b0;
            match_q    <= 1'b0;
            div_q      <= DIV_RESET;
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            baud_q     <= 16'd0;
            tx_q       <= 1'b1;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            timer_en_q <= timer_en_d;
            irq_en_q   <= irq_en_d;
            match_q    <= match_d;
            div_q      <= div_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
        end
    end

    // Transmit shift data; only meaningful while a frame is in flight
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_io_bank.sv
// tb_io_bank: directed self-checking bench for io_bank.
module tb_io_bank;

    logic        clk;
    logic        reset;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        uart_tx;
    logic        irq;

    int checks;
    int failures;
    logic exp_tx;

    io_bank #(.DIV_RESET(16'd868)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_addr       (io_addr),
        .io_en         (io_en),
        .io_we         (io_we),
        .io_data_write (io_data_write),
        .io_data_read  (io_data_read),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .uart_tx       (uart_tx),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, ending 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle write; the write lands on the next rising edge.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        io_addr       = a;
        io_data_write = d;
        io_en         = 1'b1;
        io_we         = 1'b1;
        @(posedge clk);
        #1;
        io_en = 1'b0;
        io_we = 1'b0;
    endtask

    // Combinational read checked without advancing the clock.
    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        io_addr = a;
        io_en   = 1'b1;
        io_we   = 1'b0;
        #1;
        chk(tag, io_data_read, exp);
        io_en = 1'b0;
    endtask

    // Expected line level for bit slot seg of an 8N1 frame carrying b.
    function automatic logic uart_bit(input logic [7:0] b, input int seg);
        if (seg == 0) return 1'b0;
        if (seg <= 8) return b[seg-1];
        return 1'b1;
    endfunction

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        io_addr       = 8'h0;
        io_en         = 1'b0;
        io_we         = 1'b0;
        io_data_write = 32'h0;
        gpio_in       = 8'h0;
        tick(3);
        reset = 1'b0;

        // Reset values
        rd(8'h00, 32'h0, "rst_gpio_out");
        rd(8'h08, 32'h0, "rst_count");
        rd(8'h0C, 32'hFFFF_FFFF, "rst_cmp");
        rd(8'h10, 32'h0, "rst_ctrl");
        rd(8'h14, 32'h0, "rst_status");
        rd(8'h1C, 32'h0000_0364, "rst_div");
        chk("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        io_addr = 8'h0C;
        io_en   = 1'b0;
        #1;
        chk("idle_bus_zero", io_data_read, 32'h0);

        // GPIO out: only the low byte is kept
        wr(8'h00, 32'h0000_01A5);
        chk("gpio_out_pin", {24'h0, gpio_out}, 32'hA5);
        rd(8'h00, 32'h0000_00A5, "gpio_out_read");
        wr(8'h10, 32'hFFFF_FFFC);
        rd(8'h10, 32'h0, "ctrl_unimpl_bits");

        // GPIO in: two synchronizer stages
        gpio_in = 8'h3C;
        rd(8'h04, 32'h0, "gpio_in_e0");
        tick(1);
        rd(8'h04, 32'h0, "gpio_in_e1");
        tick(1);
        rd(8'h04, 32'h3C, "gpio_in_e2");

        // Timer compare and interrupt
        wr(8'h0C, 32'd5);
        wr(8'h08, 32'd0);
        wr(8'h10, 32'd3);
        rd(8'h08, 32'd0, "cnt_start");
        tick(5);
        rd(8'h08, 32'd5, "cnt_at5");
        chk("irq_before_match", {31'h0, irq}, 32'h0);
        tick(1);
        rd(8'h08, 32'd6, "cnt_at6");
        chk("irq_on_match", {31'h0, irq}, 32'h1);
        rd(8'h14, 32'h1, "status_match");
        wr(8'h14, 32'h1);
        chk("irq_cleared", {31'h0, irq}, 32'h0);
        rd(8'h14, 32'h0, "status_cleared");

        // Simultaneous match set and W1C clear keeps match
        wr(8'h10, 32'd0);
        wr(8'h08, 32'd5);
        wr(8'h10, 32'd1);
        wr(8'h14, 32'h1);
        rd(8'h14, 32'h1, "set_beats_clear");
        chk("irq_masked", {31'h0, irq}, 32'h0);
        wr(8'h14, 32'h1);
        rd(8'h14, 32'h0, "match_clear2");

        // Write to COUNT wins over increment; wraparound
        wr(8'h08, 32'h100);
        rd(8'h08, 32'h100, "cnt_write_wins");
        tick(1);
        rd(8'h08, 32'h101, "cnt_after_write");
        wr(8'h08, 32'hFFFF_FFFE);
        rd(8'h08, 32'hFFFF_FFFE, "cnt_wrap_m2");
        tick(1);
        rd(8'h08, 32'hFFFF_FFFF, "cnt_wrap_m1");
        tick(1);
        rd(8'h08, 32'h0, "cnt_wrap_0");
        wr(8'h10, 32'd0);

        // UART frame, DIV=4, byte 0x55, extra write mid-frame dropped
        wr(8'h1C, 32'd4);
        rd(8'h1C, 32'd4, "div_read");
        rd(8'h18, 32'h0, "uart_tx_reads0");
        wr(8'h18, 32'h55);
        for (int k = 0; k < 40; k++) begin
            exp_tx = uart_bit(8'h55, k / 4);
            chk($sformatf("uart_bit_k%0d", k), {31'h0, uart_tx}, {31'h0, exp_tx});
            rd(8'h14, 32'h2, $sformatf("uart_busy_k%0d", k));
            if (k == 10) begin
                io_addr       = 8'h18;
                io_data_write = 32'hFF;
                io_en         = 1'b1;
                io_we         = 1'b1;
            end
            @(posedge clk);
            #1;
            io_en = 1'b0;
            io_we = 1'b0;
        end
        chk("uart_done_tx", {31'h0, uart_tx}, 32'h1);
        rd(8'h14, 32'h0, "uart_done_busy");
        tick(8);
        chk("uart_drop_tx", {31'h0, uart_tx}, 32'h1);
        rd(8'h14, 32'h0, "uart_drop_busy");

        // Reset mid-DATA with a concurrent write
        wr(8'h10, 32'd3);
        wr(8'h18, 32'hF0);
        tick(5);
        chk("mid_data_tx", {31'h0, uart_tx}, 32'h0);
        chk("irq_pre_reset", {31'h0, irq}, 32'h1);
        reset         = 1'b1;
        io_addr       = 8'h00;
        io_data_write = 32'hFF;
        io_en         = 1'b1;
        io_we         = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        io_en = 1'b0;
        io_we = 1'b0;
        chk("rst2_uart_tx", {31'h0, uart_tx}, 32'h1);
        chk("rst2_irq", {31'h0, irq}, 32'h0);
        chk("rst2_gpio_out", {24'h0, gpio_out}, 32'h0);
        rd(8'h14, 32'h0, "rst2_status");
        rd(8'h00, 32'h0, "rst2_gpio_read");
        rd(8'h04, 32'h0, "rst2_gpio_in");
        rd(8'h08, 32'h0, "rst2_count");
        rd(8'h0C, 32'hFFFF_FFFF, "rst2_cmp");
        rd(8'h10, 32'h0, "rst2_ctrl");
        rd(8'h1C, 32'h0000_0364, "rst2_div");

        // DIV=0 behaves as one cycle per bit
        wr(8'h1C, 32'd0);
        rd(8'h1C, 32'd0, "div0_read");
        wr(8'h18, 32'h01);
        chk("div0_start", {31'h0, uart_tx}, 32'h0);
        tick(1);
        chk("div0_bit0", {31'h0, uart_tx}, 32'h1);
        tick(1);
        chk("div0_bit1", {31'h0, uart_tx}, 32'h0);
        tick(7);
        rd(8'h14, 32'h2, "div0_stop_busy");
        chk("div0_stop_tx", {31'h0, uart_tx}, 32'h1);
        tick(1);
        rd(8'h14, 32'h0, "div0_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
